// File: rtl/time_counter_n.sv
// rtl/time_counter_n.sv - prescaled up/down game-timer counter with tc pulse and sticky done
// Optional snapshot-hold output enabled by defining TIME_COUNTER_HOLD_EN.
module time_counter_n #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4,
   parameter int WRAP  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   input  logic             ld,
`ifdef TIME_COUNTER_HOLD_EN
   input  logic             hold,
`endif
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] tout,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] MAX      = '1;
   localparam logic [7:0]       PRE_LAST = 8'(DIV - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [7:0]       presc_q, presc_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             step;
   logic [WIDTH-1:0] term;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      step    = 1'b0;
      term    = dir ? '0 : MAX;
      nxt     = dir ? count_q - 1'b1 : count_q + 1'b1;
      if (clr) begin
         count_d = '0;
         presc_d = '0;
         done_d  = 1'b0;
      end else if (ld) begin
         count_d = d;
         presc_d = '0;
         done_d  = 1'b0;
      end else if (en && inc) begin
         if (presc_q == PRE_LAST) begin
            presc_d = '0;
            step    = 1'b1;
         end else begin
            presc_d = presc_q + 8'd1;
         end
      end
      // Stepping from terminal either wraps silently or saturates; only arrival fires tc.
      if (step) begin
         if (count_q == term) begin
            if (WRAP != 0) begin
               count_d = dir ? MAX : '0;
            end
         end else begin
            count_d = nxt;
            if (nxt == term) begin
               tc_d   = 1'b1;
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         presc_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign tc   = tc_q;
   assign done = done_q;

`ifdef TIME_COUNTER_HOLD_EN
   logic             hold_q, hold_d;
   logic [WIDTH-1:0] snap_q, snap_d;

   always_comb begin
      hold_d = hold;
      snap_d = snap_q;
      if (hold && !hold_q) begin
         snap_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= 1'b0;
         snap_q <= '0;
      end else begin
         hold_q <= hold_d;
         snap_q <= snap_d;
      end
   end

   assign tout = hold_q ? snap_q : count_q;
`else
   assign tout = count_q;
`endif

endmodule

// File: tb/tb_time_counter_n.sv
// tb/tb_time_counter_n.sv - randomized and directed checks of time_counter_n against an arithmetic model
module tb_time_counter_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_r = 1'b1, inc_r = 1'b0, en_r = 1'b0, dir_r = 1'b0;
   logic        clr_r = 1'b0, ld_r = 1'b0, hold_r = 1'b0;
   logic [15:0] d_v = '0;
   logic [7:0]  t0;
   logic [3:0]  t1, t2, t3;
   logic [3:0]  tc_v, done_v;

   int vectors = 0;
   int miscompares = 0;

   int W_[4]  = '{8, 4, 4, 4};
   int DV_[4] = '{4, 1, 1, 3};
   int WR_[4] = '{0, 0, 1, 1};
   int mc[4], mp[4], mtc[4], mdone[4], mh[4], ms[4];

   time_counter_n #(.WIDTH(8), .DIV(4), .WRAP(0)) u0 (.clk(clk), .reset(reset_r), .inc(inc_r),
      .en(en_r), .dir(dir_r), .clr(clr_r), .ld(ld_r),
`ifdef TIME_COUNTER_HOLD_EN
      .hold(hold_r),
`endif
      .d(d_v[7:0]), .tout(t0), .tc(tc_v[0]), .done(done_v[0]));
   time_counter_n #(.WIDTH(4), .DIV(1), .WRAP(0)) u1 (.clk(clk), .reset(reset_r), .inc(inc_r),
      .en(en_r), .dir(dir_r), .clr(clr_r), .ld(ld_r),
`ifdef TIME_COUNTER_HOLD_EN
      .hold(hold_r),
`endif
      .d(d_v[3:0]), .tout(t1), .tc(tc_v[1]), .done(done_v[1]));
   time_counter_n #(.WIDTH(4), .DIV(1), .WRAP(1)) u2 (.clk(clk), .reset(reset_r), .inc(inc_r),
      .en(en_r), .dir(dir_r), .clr(clr_r), .ld(ld_r),
`ifdef TIME_COUNTER_HOLD_EN
      .hold(hold_r),
`endif
      .d(d_v[3:0]), .tout(t2), .tc(tc_v[2]), .done(done_v[2]));
   time_counter_n #(.WIDTH(4), .DIV(3), .WRAP(1)) u3 (.clk(clk), .reset(reset_r), .inc(inc_r),
      .en(en_r), .dir(dir_r), .clr(clr_r), .ld(ld_r),
`ifdef TIME_COUNTER_HOLD_EN
      .hold(hold_r),
`endif
      .d(d_v[3:0]), .tout(t3), .tc(tc_v[3]), .done(done_v[3]));

   task automatic check(input string tag, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int tout_of(input int i);
      case (i)
         0: return int'(t0);
         1: return int'(t1);
         2: return int'(t2);
         default: return int'(t3);
      endcase
   endfunction

   function automatic int exp_tout(input int i);
`ifdef TIME_COUNTER_HOLD_EN
      if (mh[i] != 0) return ms[i];
`endif
      return mc[i];
   endfunction

   // Reference: count steps once per DIV qualified incs; terminal is max going up, 0 going down.
   task automatic update_model();
      for (int i = 0; i < 4; i++) begin
         int mx = (1 << W_[i]) - 1;
         int term = dir_r ? 0 : mx;
         if (reset_r) begin
            mh[i] = 0;
            ms[i] = 0;
         end else begin
            if (hold_r && mh[i] == 0) ms[i] = mc[i];
            mh[i] = int'(hold_r);
         end
         mtc[i] = 0;
         if (reset_r) begin
            mc[i] = 0; mp[i] = 0; mdone[i] = 0;
         end else if (clr_r) begin
            mc[i] = 0; mp[i] = 0; mdone[i] = 0;
         end else if (ld_r) begin
            mc[i] = int'(d_v) % (mx + 1); mp[i] = 0; mdone[i] = 0;
         end else if (en_r && inc_r) begin
            mp[i]++;
            if (mp[i] == DV_[i]) begin
               mp[i] = 0;
               if (mc[i] == term) begin
                  if (WR_[i] != 0) mc[i] = dir_r ? mx : 0;
               end else begin
                  mc[i] = dir_r ? mc[i] - 1 : mc[i] + 1;
                  if (mc[i] == term) begin
                     mtc[i] = 1;
                     mdone[i] = 1;
                  end
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      update_model();
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("tout%0d", i), tout_of(i), exp_tout(i));
         check($sformatf("tc%0d", i), int'(tc_v[i]), mtc[i]);
         check($sformatf("done%0d", i), int'(done_v[i]), mdone[i]);
      end
   endtask

   task automatic set_in(input logic rs, input logic c, input logic l, input logic e,
                         input logic dr, input logic ic, input int dv);
      reset_r = rs; clr_r = c; ld_r = l; en_r = e; dir_r = dr; inc_r = ic; d_v = 16'(dv);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         mc[i] = 0; mp[i] = 0; mtc[i] = 0; mdone[i] = 0; mh[i] = 0; ms[i] = 0;
      end
      set_in(1, 0, 0, 0, 0, 0, 0);
      cycle(); cycle();
      check("reset_tout", int'(t0), 0);
      check("reset_done", int'(done_v[0]), 0);

      // 12 incs at DIV=4 -> 3
      set_in(0, 0, 0, 1, 0, 1, 0);
      for (int k = 0; k < 12; k++) begin
         cycle();
         check("up_tc", int'(tc_v[0]), 0);
      end
      check("up12_tout", int'(t0), 3);

      // Saturate at 15 (WIDTH=4, WRAP=0)
      set_in(0, 0, 1, 1, 0, 0, 14); cycle();
      check("ld14", int'(t1), 14);
      set_in(0, 0, 0, 1, 0, 1, 0); cycle();
      check("sat_tout", int'(t1), 15);
      check("sat_tc", int'(tc_v[1]), 1);
      check("sat_done", int'(done_v[1]), 1);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("sat_hold", int'(t1), 15);
         check("sat_notc", int'(tc_v[1]), 0);
         check("sat_done_keep", int'(done_v[1]), 1);
      end

      // Down-count wrap (WIDTH=4, WRAP=1)
      set_in(0, 0, 1, 1, 1, 0, 1); cycle();
      set_in(0, 0, 0, 1, 1, 1, 0); cycle();
      check("wrap_zero", int'(t2), 0);
      check("wrap_tc1", int'(tc_v[2]), 1);
      cycle();
      check("wrap_max", int'(t2), 15);
      check("wrap_notc", int'(tc_v[2]), 0);
      for (int k = 0; k < 15; k++) cycle();
      check("wrap_zero2", int'(t2), 0);
      check("wrap_tc2", int'(tc_v[2]), 1);

      // clr+ld+inc with prescaler at DIV-1, then prescaler restarts from 0
      set_in(0, 1, 0, 1, 0, 0, 0); cycle();
      set_in(0, 0, 0, 1, 0, 1, 0);
      for (int k = 0; k < 3; k++) cycle();
      set_in(0, 1, 1, 1, 0, 1, 9); cycle();
      check("clr_pri_tout", int'(t0), 0);
      check("clr_pri_tc", int'(tc_v[0]), 0);
      check("clr_pri_done", int'(done_v[0]), 0);
      set_in(0, 0, 0, 1, 0, 1, 0);
      for (int k = 0; k < 3; k++) cycle();
      check("presc_cleared", int'(t0), 0);
      cycle();
      check("presc_step", int'(t0), 1);
      set_in(1, 0, 1, 1, 0, 1, 5); cycle();
      check("reset_pri", int'(t0), 0);

      // Freeze with en=0 preserves prescaler phase; ld still acts
      set_in(0, 0, 0, 1, 0, 1, 0); cycle(); cycle();
      set_in(0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("frozen", int'(t0), 0);
      end
      set_in(0, 0, 0, 1, 0, 1, 0); cycle();
      check("thaw1", int'(t0), 0);
      cycle();
      check("thaw2", int'(t0), 1);
      set_in(0, 0, 1, 0, 0, 1, 5); cycle();
      check("ld_frozen", int'(t0), 5);

      // Random phase
      set_in(0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 3000; k++) begin
         reset_r = ($urandom_range(0, 299) == 0);
         clr_r   = ($urandom_range(0, 149) == 0);
         ld_r    = ($urandom_range(0, 59) == 0);
         en_r    = ($urandom_range(0, 9) != 0);
         inc_r   = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 39) == 0) dir_r = ~dir_r;
         if ($urandom_range(0, 19) == 0) hold_r = ~hold_r;
         d_v     = 16'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
